// File: rtl/vga_timing_monitor.sv
// Measures incoming hSync/vSync timing against an expected VGA geometry and
// declares lock after LOCK_FRAMES consecutive frames that match it.
module vga_timing_monitor #(
  parameter int H_PERIOD_EXP = 3200,
  parameter int H_PULSE_EXP  = 384,
  parameter int V_LINES_EXP  = 525,
  parameter int V_PULSE_EXP  = 2,
  parameter int TOL          = 4,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic        hSync,
  input  logic        vSync,
  output logic        locked,
  output logic        frame_tick,
  output logic        err_pulse,
  output logic [11:0] h_period,
  output logic [11:0] h_width,
  output logic [9:0]  v_lines,
  output logic [3:0]  v_width,
  output logic [9:0]  line_pos,
  output logic [7:0]  err_count
);
  typedef enum logic [1:0] {S_SEARCH, S_ACQUIRE, S_LOCKED} state_t;

  localparam logic [11:0]        HCNT_MAX = 12'hFFF;
  localparam logic [9:0]         LCNT_MAX = 10'h3FF;
  localparam logic signed [13:0] H_PER_S  = 14'(H_PERIOD_EXP);
  localparam logic signed [13:0] H_PUL_S  = 14'(H_PULSE_EXP);
  localparam logic signed [13:0] TOL_S    = 14'(TOL);

  logic        r_hs_s1, r_hs_s2, r_hs_prev;
  logic        r_vs_s1, r_vs_s2, r_vs_prev;
  logic [11:0] r_hcnt, r_h_period, r_h_width;
  logic [9:0]  r_lcnt, r_v_lines;
  logic [3:0]  r_vwcnt, r_v_width;
  logic        r_line_bad, r_frame_tick;
  logic        r_locked, r_err_pulse;
  logic [7:0]  r_err_count, r_good_cnt;
  state_t      r_state;

  logic        w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise;
  logic signed [13:0] w_hper_diff, w_hwid_diff;
  logic        w_line_err, w_frame_ok, w_timeout, w_lose_lock;
  state_t      w_state_next;
  logic [7:0]  w_good_next;

  assign w_hs_fall = r_hs_prev & ~r_hs_s2;
  assign w_hs_rise = ~r_hs_prev & r_hs_s2;
  assign w_vs_fall = r_vs_prev & ~r_vs_s2;
  assign w_vs_rise = ~r_vs_prev & r_vs_s2;

  assign w_hper_diff = $signed({2'b00, r_hcnt}) - H_PER_S;
  assign w_hwid_diff = $signed({2'b00, r_h_width}) - H_PUL_S;
  assign w_line_err  = (w_hper_diff > TOL_S) || (w_hper_diff < -TOL_S) ||
                       (w_hwid_diff > TOL_S) || (w_hwid_diff < -TOL_S);

  // line_bad is sampled here before its clear-on-vSync-fall takes effect
  assign w_frame_ok = !r_line_bad && (r_lcnt == 10'(V_LINES_EXP)) &&
                      (r_v_width == 4'(V_PULSE_EXP));
  assign w_timeout  = (r_hcnt == HCNT_MAX) || (r_lcnt == LCNT_MAX);

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_hs_s1      <= 1'b1;
      r_hs_s2      <= 1'b1;
      r_hs_prev    <= 1'b1;
      r_vs_s1      <= 1'b1;
      r_vs_s2      <= 1'b1;
      r_vs_prev    <= 1'b1;
      r_hcnt       <= '0;
      r_h_period   <= '0;
      r_h_width    <= '0;
      r_lcnt       <= '0;
      r_v_lines    <= '0;
      r_vwcnt      <= '0;
      r_v_width    <= '0;
      r_line_bad   <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_hs_s1      <= hSync;
      r_hs_s2      <= r_hs_s1;
      r_hs_prev    <= r_hs_s2;
      r_vs_s1      <= vSync;
      r_vs_s2      <= r_vs_s1;
      r_vs_prev    <= r_vs_s2;
      r_frame_tick <= w_vs_fall;

      if (w_hs_fall) begin
        r_hcnt     <= 12'd1;
        r_h_period <= r_hcnt;
      end else if (r_hcnt != HCNT_MAX) begin
        r_hcnt <= r_hcnt + 12'd1;
      end
      if (w_hs_rise) r_h_width <= r_hcnt;

      // An hSync fall coincident with the vSync fall belongs to the new frame
      if (w_vs_fall) begin
        r_v_lines <= r_lcnt;
        r_lcnt    <= w_hs_fall ? 10'd1 : 10'd0;
      end else if (w_hs_fall && (r_lcnt != LCNT_MAX)) begin
        r_lcnt <= r_lcnt + 10'd1;
      end

      if (w_vs_fall) begin
        r_vwcnt <= w_hs_fall ? 4'd1 : 4'd0;
      end else if (w_hs_fall && !r_vs_s2 && (r_vwcnt != 4'hF)) begin
        r_vwcnt <= r_vwcnt + 4'd1;
      end
      if (w_vs_rise) r_v_width <= r_vwcnt;

      if (w_vs_fall) begin
        r_line_bad <= w_hs_fall && w_line_err;
      end else if (w_hs_fall && w_line_err) begin
        r_line_bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_SEARCH;
      r_good_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_good_cnt <= w_good_next;
    end
  end

  // Timeout is checked first so it overrides a coincident vSync fall
  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good_cnt;
    if (w_timeout) begin
      w_state_next = S_SEARCH;
      w_good_next  = '0;
    end else if (w_vs_fall) begin
      case (r_state)
        S_SEARCH: begin
          w_state_next = S_ACQUIRE;
          w_good_next  = '0;
        end
        S_ACQUIRE: begin
          if (w_frame_ok) begin
            w_good_next = r_good_cnt + 8'd1;
            if (w_good_next >= 8'(LOCK_FRAMES)) w_state_next = S_LOCKED;
          end else begin
            w_good_next = '0;
          end
        end
        S_LOCKED: begin
          if (!w_frame_ok) w_state_next = S_SEARCH;
        end
        default: w_state_next = S_SEARCH;
      endcase
    end
  end

  always_comb begin
    w_lose_lock = (r_state == S_LOCKED) && (w_state_next != S_LOCKED);
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_locked    <= (w_state_next == S_LOCKED);
      r_err_pulse <= w_lose_lock;
      if (w_lose_lock && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign locked     = r_locked;
  assign frame_tick = r_frame_tick;
  assign err_pulse  = r_err_pulse;
  assign h_period   = r_h_period;
  assign h_width    = r_h_width;
  assign v_lines    = r_v_lines;
  assign v_width    = r_v_width;
  assign line_pos   = r_lcnt;
  assign err_count  = r_err_count;

endmodule
